// File: rtl/mandelbrot_pixel_scheduler.sv
// Walks an H_RES x V_RES pixel grid in raster order, feeds each pixel's 4.23 coordinate
// to the iterator and writes the returned iteration count plus a derived colour to the framebuffer.
module mandelbrot_pixel_scheduler #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [26:0] cr_init,
  input  logic signed [26:0] ci_init,
  input  logic signed [26:0] dr,
  input  logic signed [26:0] di,
  input  logic [15:0]        max_iterations,
  output logic signed [26:0] iter_cr,
  output logic signed [26:0] iter_ci,
  output logic [15:0]        iter_max,
  output logic               iter_reset,
  input  logic               iter_done,
  input  logic [15:0]        iter_count,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [15:0]        wr_count,
  output logic [7:0]         wr_color,
  output logic               busy,
  output logic               frame_done,
  output logic [2:0]         dbg_state
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic signed [26:0]   cr_q, cr_d;
  logic signed [26:0]   ci_q, ci_d;
  logic signed [26:0]   cr_init_q, cr_init_d;
  logic signed [26:0]   dr_q, dr_d;
  logic signed [26:0]   di_q, di_d;
  logic [15:0]          max_q, max_d;
  logic [15:0]          count_q, count_d;
  logic [7:0]           color_q, color_d;
  logic                 last_pixel;

  assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

  // Iterator handshake: iter_reset=1 loads iter_cr/iter_ci/iter_max into the iterator;
  // once it drops, the iterator runs until it raises iter_done for one or more cycles,
  // and iter_count is consumed on the first cycle iter_done is seen high in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_WAIT;
      S_WAIT:  if (iter_done) state_d = S_WRITE;
      S_WRITE: state_d = last_pixel ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    iter_reset = (state_q == S_IDLE) || (state_q == S_LOAD);
    wr_en      = (state_q == S_WRITE);
    frame_done = (state_q == S_DONE);
    dbg_state  = state_q;
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    cr_d      = cr_q;
    ci_d      = ci_q;
    cr_init_d = cr_init_q;
    dr_d      = dr_q;
    di_d      = di_q;
    max_d     = max_q;
    count_d   = count_q;
    color_d   = color_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cr_init_d = cr_init;
          dr_d      = dr;
          di_d      = di;
          max_d     = max_iterations;
          x_d       = '0;
          y_d       = '0;
          addr_d    = '0;
          cr_d      = cr_init;
          ci_d      = ci_init;
        end
      end
      S_WAIT: begin
        if (iter_done) begin
          count_d = iter_count;
          // Points that hit the cap are inside the set; escaping points never map to black.
          color_d = (iter_count >= max_q) ? 8'h00 : (iter_count[7:0] | 8'h01);
        end
      end
      S_WRITE: begin
        if (x_q != X_LAST) begin
          x_d  = x_q + XW'(1);
          cr_d = cr_q + dr_q;
        end else begin
          x_d  = '0;
          cr_d = cr_init_q;
          y_d  = y_q + YW'(1);
          ci_d = ci_q - di_q;
        end
        addr_d = addr_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      cr_q      <= '0;
      ci_q      <= '0;
      cr_init_q <= '0;
      dr_q      <= '0;
      di_q      <= '0;
      max_q     <= '0;
      count_q   <= '0;
      color_q   <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      cr_q      <= cr_d;
      ci_q      <= ci_d;
      cr_init_q <= cr_init_d;
      dr_q      <= dr_d;
      di_q      <= di_d;
      max_q     <= max_d;
      count_q   <= count_d;
      color_q   <= color_d;
    end
  end

  assign iter_cr  = cr_q;
  assign iter_ci  = ci_q;
  assign iter_max = max_q;
  assign wr_addr  = addr_q;
  assign wr_count = count_q;
  assign wr_color = color_q;

endmodule
